// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//  Shared definitions for the seven-segment display blocks.
//  - Scan FSM state encoding (OFF / BLANK / DRIVE).
//  - Hex glyph constants SEG_0..SEG_F, bit order {dp,g,f,e,d,c,b,a}, dp clear.
//  - hex_glyph(): 4-bit value -> glyph constant.
// ---------------------------------------------------------------------------
package seg_pkg;

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   localparam logic [7:0] SEG_OFF = 8'h00;
   localparam logic [7:0] SEG_0   = 8'h3F;
   localparam logic [7:0] SEG_1   = 8'h06;
   localparam logic [7:0] SEG_2   = 8'h5B;
   localparam logic [7:0] SEG_3   = 8'h4F;
   localparam logic [7:0] SEG_4   = 8'h66;
   localparam logic [7:0] SEG_5   = 8'h6D;
   localparam logic [7:0] SEG_6   = 8'h7D;
   localparam logic [7:0] SEG_7   = 8'h07;
   localparam logic [7:0] SEG_8   = 8'h7F;
   localparam logic [7:0] SEG_9   = 8'h6F;
   localparam logic [7:0] SEG_A   = 8'h77;
   localparam logic [7:0] SEG_B   = 8'h7C;
   localparam logic [7:0] SEG_C   = 8'h39;
   localparam logic [7:0] SEG_D   = 8'h5E;
   localparam logic [7:0] SEG_E   = 8'h79;
   localparam logic [7:0] SEG_F   = 8'h71;

   function automatic logic [7:0] hex_glyph(input logic [3:0] v);
      logic [7:0] g;
      case (v)
         4'h0: g = SEG_0;
         4'h1: g = SEG_1;
         4'h2: g = SEG_2;
         4'h3: g = SEG_3;
         4'h4: g = SEG_4;
         4'h5: g = SEG_5;
         4'h6: g = SEG_6;
         4'h7: g = SEG_7;
         4'h8: g = SEG_8;
         4'h9: g = SEG_9;
         4'hA: g = SEG_A;
         4'hB: g = SEG_B;
         4'hC: g = SEG_C;
         4'hD: g = SEG_D;
         4'hE: g = SEG_E;
         default: g = SEG_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// ---------------------------------------------------------------------------
// seg_hex_decode
//  Combinational hex-to-seven-segment decoder with decimal point and blanking.
//  Ports:
//   hex_i    in  4   value to show (0-F)
//   dp_i     in  1   decimal point
//   blank_i  in  1   1 = all segments off, dp included
//   seg_o    out 8   {dp,g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   logic [7:0] glyph;

   always_comb begin
      glyph = hex_glyph(hex_i);
      // glyph constants keep bit 7 clear, so OR-ing dp in is safe
      if (blank_i) seg_o = SEG_OFF;
      else         seg_o = glyph | {dp_i, 7'b0};
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//  Time-multiplexed scan controller: one 8-bit segment bus shared by
//  NUM_DIGITS digits, one digit driven at a time with an all-off gap before
//  each digit. New digit data is double-buffered (pending -> shadow) and only
//  reaches the display at a frame boundary (entry into the digit-0 slot).
//  Ports:
//   clk          in   1             clock, rising edge
//   rst          in   1             synchronous reset, active low
//   enable       in   1             1 = scan, 0 = dark
//   load         in   1             strobe: capture digits_in/dp_in/blank_in
//   digits_in    in   4*NUM_DIGITS  hex per digit, digit 0 in [3:0]
//   dp_in        in   NUM_DIGITS    decimal point per digit
//   blank_in     in   NUM_DIGITS    1 = digit dark
//   seg          out  8             {dp,g,f,e,d,c,b,a}
//   an           out  NUM_DIGITS    one-hot digit select, 0 in gap/off
//   load_ack     out  1             pulse: captured data now on display
//   frame_start  out  1             pulse: first cycle of a frame
// ---------------------------------------------------------------------------
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DWELL_CYC  = 1000,
   parameter int BLANK_CYC  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank_in,
   output logic [7:0]                seg,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      load_ack,
   output logic                      frame_start
);

   localparam int TMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int IW   = $clog2(NUM_DIGITS);

   // timers hold "cycles remaining - 1", so a slot ends when timer reads 0
   localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYC - 1);
   localparam logic [TW-1:0] BLANK_LD = TW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   logic [1:0]              state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic                    boundary, start_slot;

   logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, sh_dig_q, sh_dig_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   pend_blk_q, pend_blk_d, sh_blk_q, sh_blk_d;
   logic                    pend_vld_q, pend_vld_d;

   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    ack_q, ack_d, fs_q, fs_d;

   logic [3:0]              dec_hex;
   logic                    dec_dp, dec_blk;
   logic [7:0]              dec_seg;

   // ---- scan FSM / timer / digit index ----
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      boundary   = 1'b0;
      start_slot = 1'b0;
      if (!enable) begin
         state_d = ST_OFF;
         idx_d   = '0;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (timer_q == '0) begin
                  state_d = ST_DRIVE;
                  timer_d = DWELL_LD;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            ST_DRIVE: begin
               if (timer_q == '0) begin
                  boundary   = (idx_q == LAST_IDX);
                  idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                  start_slot = 1'b1;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            default: begin
               // OFF (or an unreachable code): start a fresh frame
               boundary   = 1'b1;
               idx_d      = '0;
               start_slot = 1'b1;
            end
         endcase
         if (start_slot) begin
            // with no gap configured a slot opens straight into DRIVE
            state_d = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;
            timer_d = (BLANK_CYC == 0) ? DWELL_LD : BLANK_LD;
         end
      end
   end

   // ---- pending / shadow double buffer ----
   always_comb begin
      pend_dig_d = pend_dig_q;
      pend_dp_d  = pend_dp_q;
      pend_blk_d = pend_blk_q;
      pend_vld_d = pend_vld_q;
      sh_dig_d   = sh_dig_q;
      sh_dp_d    = sh_dp_q;
      sh_blk_d   = sh_blk_q;
      if (boundary) begin
         // a load on the boundary cycle bypasses pending entirely
         if (load) begin
            sh_dig_d = digits_in;
            sh_dp_d  = dp_in;
            sh_blk_d = blank_in;
         end else if (pend_vld_q) begin
            sh_dig_d = pend_dig_q;
            sh_dp_d  = pend_dp_q;
            sh_blk_d = pend_blk_q;
         end
         pend_vld_d = 1'b0;
      end else if (load) begin
         pend_dig_d = digits_in;
         pend_dp_d  = dp_in;
         pend_blk_d = blank_in;
         pend_vld_d = 1'b1;
      end
   end

   // outputs are registered from next-state values so they line up with
   // the slot being entered, including the boundary shadow update
   assign dec_hex = sh_dig_d[4*idx_d +: 4];
   assign dec_dp  = sh_dp_d[idx_d];
   assign dec_blk = sh_blk_d[idx_d];

   seg_hex_decode u_dec (
      .hex_i   (dec_hex),
      .dp_i    (dec_dp),
      .blank_i (dec_blk),
      .seg_o   (dec_seg)
   );

   always_comb begin
      if (state_d == ST_DRIVE) begin
         an_d  = NUM_DIGITS'(1) << idx_d;
         seg_d = dec_seg;
      end else begin
         an_d  = '0;
         seg_d = SEG_OFF;
      end
      fs_d  = boundary;
      ack_d = boundary & (load | pend_vld_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_OFF;
         idx_q      <= '0;
         timer_q    <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pend_blk_q <= '0;
         pend_vld_q <= 1'b0;
         sh_dig_q   <= '0;
         sh_dp_q    <= '0;
         sh_blk_q   <= '0;
         seg_q      <= SEG_OFF;
         an_q       <= '0;
         ack_q      <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         pend_blk_q <= pend_blk_d;
         pend_vld_q <= pend_vld_d;
         sh_dig_q   <= sh_dig_d;
         sh_dp_q    <= sh_dp_d;
         sh_blk_q   <= sh_blk_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         ack_q      <= ack_d;
         fs_q       <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign load_ack    = ack_q;
   assign frame_start = fs_q;

endmodule
